// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: state encodings, timer width,
// and the per-stage control bundle with its canonical patterns.
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALTED   = 2'd2;
    localparam logic [1:0] ST_STEP     = 2'd3;

    localparam int unsigned DEF_MEM_TIMEOUT = 16;
    localparam int unsigned TIMER_W         = 8;

    typedef struct packed {
        logic pc_write;
        logic if_write;
        logic ex_write;
        logic mem_write;
        logic wb_write;
        logic if_flush;
        logic id_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN    = ctrl_t'(7'b11111_00);
    localparam ctrl_t CTRL_REDIR  = ctrl_t'(7'b11111_10);
    // Front end held with a bubble into ID/EX; shared by load-use stall and halt.
    localparam ctrl_t CTRL_HOLD   = ctrl_t'(7'b00111_01);
    localparam ctrl_t CTRL_FREEZE = ctrl_t'(7'b00000_00);
    localparam ctrl_t CTRL_RESET  = ctrl_t'(7'b00000_11);

    function automatic ctrl_t run_ctrl(input logic stall, input logic redirect);
        if (stall)
            return CTRL_HOLD;
        else if (redirect)
            return CTRL_REDIR;
        else
            return CTRL_RUN;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive data-memory wait cycles; expired flags the cycle whose
// increment would reach LIMIT.
module mem_wait_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned LIMIT = DEF_MEM_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [TIMER_W-1:0] count;

    assign expired = inc && (count == TIMER_W'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            count <= '0;
        else if (inc)
            count <= count + TIMER_W'(1);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges hazard, memory-wait and debug requests into
// per-stage enables/flushes and counts front-end stall cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Stall,
    input  logic             Branch,
    input  logic             Jump,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             dbg_halt,
    input  logic             dbg_step,
    output logic             PCWrite,
    output logic             IFWrite,
    output logic             IF_flush,
    output logic             ID_flush,
    output logic             EXWrite,
    output logic             MEMWrite,
    output logic             WBWrite,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] perf_stall_cnt
);

    logic [1:0] state;
    logic [1:0] next_state;
    ctrl_t      ctrl;
    ctrl_t      ctrl_out;
    logic       mem_stall;
    logic       in_wait;
    logic       live;
    logic       timer_inc;
    logic       timer_clr;
    logic       timer_expired;
    logic       set_err;

    assign mem_stall = dmem_req && !dmem_ready;
    assign in_wait   = (state == ST_MEM_WAIT);
    assign live      = (state == ST_RUN) || (state == ST_STEP);
    assign timer_inc = (live && mem_stall) || (in_wait && !dmem_ready);
    assign timer_clr = in_wait && (dmem_ready || timer_expired);
    assign set_err   = in_wait && timer_expired;

    mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr),
        .inc     (timer_inc),
        .expired (timer_expired)
    );

    always_comb begin
        ctrl       = CTRL_FREEZE;
        next_state = state;
        case (state)
            ST_RUN: begin
                if (mem_stall) begin
                    next_state = ST_MEM_WAIT;
                end else if (dbg_halt) begin
                    ctrl       = CTRL_HOLD;
                    next_state = ST_HALTED;
                end else begin
                    ctrl = run_ctrl(Stall, Branch | Jump);
                end
            end
            ST_STEP: begin
                if (mem_stall) begin
                    next_state = ST_MEM_WAIT;
                end else begin
                    ctrl       = run_ctrl(Stall, Branch | Jump);
                    next_state = dbg_halt ? ST_HALTED : ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (!dmem_ready) begin
                    if (timer_expired)
                        next_state = ST_HALTED;
                end else if (dbg_halt) begin
                    ctrl       = CTRL_HOLD;
                    next_state = ST_HALTED;
                end else begin
                    ctrl       = run_ctrl(Stall, Branch | Jump);
                    next_state = ST_RUN;
                end
            end
            default: begin
                // HALTED: keep draining; a sticky memory error pins the halt.
                ctrl = CTRL_HOLD;
                if (!mem_err) begin
                    if (!dbg_halt)
                        next_state = ST_RUN;
                    else if (dbg_step)
                        next_state = ST_STEP;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_RUN;
            mem_err        <= 1'b0;
            perf_stall_cnt <= '0;
        end else begin
            state <= next_state;
            if (set_err)
                mem_err <= 1'b1;
            if (!ctrl.pc_write && (state != ST_HALTED))
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
        end
    end

    assign ctrl_out = rst_n ? ctrl : CTRL_RESET;
    assign PCWrite  = ctrl_out.pc_write;
    assign IFWrite  = ctrl_out.if_write;
    assign EXWrite  = ctrl_out.ex_write;
    assign MEMWrite = ctrl_out.mem_write;
    assign WBWrite  = ctrl_out.wb_write;
    assign IF_flush = ctrl_out.if_flush;
    assign ID_flush = ctrl_out.id_flush;
    assign halted   = rst_n && (state == ST_HALTED);

endmodule
